// File: rtl/fifo_pkg.sv
// Pointer encoding helpers shared by the FIFO read and write controllers.
// Callers zero-extend a pointer to PTR_MAX_W bits and cast the result back down.
package fifo_pkg;

    localparam int unsigned PTR_MAX_W = 32;

    typedef logic [PTR_MAX_W-1:0] ptr_max_t;

    function automatic ptr_max_t bin2gray(input ptr_max_t b);
        return b ^ (b >> 1);
    endfunction

    // Upper bits are zero after extension, so folding every shift in is width-independent.
    function automatic ptr_max_t gray2bin(input ptr_max_t g);
        ptr_max_t b;
        b = g;
        for (int unsigned i = 1; i < PTR_MAX_W; i++) begin
            b = b ^ (g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a Gray-coded pointer crossing into this clock domain.
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] ff1_d, ff1_q;
    logic [WIDTH-1:0] ff2_d, ff2_q;

    always_comb begin
        ff1_d = d;
        ff2_d = ff1_q;
    end

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            ff1_q <= '0;
            ff2_q <= '0;
        end else begin
            ff1_q <= ff1_d;
            ff2_q <= ff2_d;
        end
    end

    assign q = ff2_q;

endmodule

// File: rtl/controller_rd.sv
// Read-side pointer controller of the async FIFO: read address/enable, empty, count, rvalid.
// Optional almost_empty output enabled by defining CONTROLLER_RD_ALMOST_EMPTY_EN.
module controller_rd
    import fifo_pkg::*;
#(
    parameter int unsigned PTRWIDTH = 4
`ifdef CONTROLLER_RD_ALMOST_EMPTY_EN
    , parameter int unsigned ALMOST_EMPTY_TH = 2
`endif
) (
    input  logic              rclk,
    input  logic              reset_L,
    input  logic              pop,
    input  logic [PTRWIDTH:0] wrptr_gray,
    output logic              empty,
    output logic              rd_en,
    output logic [PTRWIDTH:0] rdptr_bin,
    output logic [PTRWIDTH:0] rdptr_gray,
    output logic              rvalid,
    output logic [PTRWIDTH:0] rdcount
`ifdef CONTROLLER_RD_ALMOST_EMPTY_EN
    , output logic            almost_empty
`endif
);

    typedef logic [PTRWIDTH:0] ptr_t;

    ptr_t wrptr_gray_ff2;
    ptr_t wrptr_sync_bin;
    ptr_t rdptr_next;
    ptr_t rdptr_bin_d, rdptr_bin_q;
    ptr_t rdptr_gray_d, rdptr_gray_q;
    logic rvalid_d, rvalid_q;

    sync_2ff #(
        .WIDTH(PTRWIDTH + 1)
    ) u_wrptr_sync (
        .clk    (rclk),
        .reset_L(reset_L),
        .d      (wrptr_gray),
        .q      (wrptr_gray_ff2)
    );

    assign wrptr_sync_bin = ptr_t'(gray2bin(ptr_max_t'(wrptr_gray_ff2)));

    // Full compare including the wrap bit: equal low bits with differing wrap bit is full.
    always_comb begin
        empty        = !reset_L || (rdptr_bin_q == wrptr_sync_bin);
        rd_en        = pop && !empty;
        rdptr_next   = rdptr_bin_q + ptr_t'(rd_en);
        rdptr_bin_d  = rdptr_next;
        rdptr_gray_d = ptr_t'(bin2gray(ptr_max_t'(rdptr_next)));
        rvalid_d     = rd_en;
    end

    always_ff @(posedge rclk) begin
        if (!reset_L) begin
            rdptr_bin_q  <= '0;
            rdptr_gray_q <= '0;
            rvalid_q     <= 1'b0;
        end else begin
            rdptr_bin_q  <= rdptr_bin_d;
            rdptr_gray_q <= rdptr_gray_d;
            rvalid_q     <= rvalid_d;
        end
    end

    assign rdptr_bin  = rdptr_bin_q;
    assign rdptr_gray = rdptr_gray_q;
    assign rvalid     = rvalid_q;
    assign rdcount    = wrptr_sync_bin - rdptr_bin_q;

`ifdef CONTROLLER_RD_ALMOST_EMPTY_EN
    assign almost_empty = !reset_L || (32'(rdcount) <= ALMOST_EMPTY_TH);
`endif

endmodule

// File: tb/tb_controller_rd.sv
// Directed bench for controller_rd (PTRWIDTH=4) with a cycle model and a read-pointer scoreboard.
module tb_controller_rd;

    localparam int PW = 4;
    localparam int W  = PW + 1;

    logic         rclk = 1'b0;
    logic         reset_L = 1'b0;
    logic         pop = 1'b0;
    logic [W-1:0] wrptr_gray = '0;
    logic         empty, rd_en, rvalid;
    logic [W-1:0] rdptr_bin, rdptr_gray, rdcount;
`ifdef CONTROLLER_RD_ALMOST_EMPTY_EN
    logic         almost_empty;
`endif

    controller_rd #(
        .PTRWIDTH(PW)
`ifdef CONTROLLER_RD_ALMOST_EMPTY_EN
        , .ALMOST_EMPTY_TH(2)
`endif
    ) dut (
        .rclk      (rclk),
        .reset_L   (reset_L),
        .pop       (pop),
        .wrptr_gray(wrptr_gray),
        .empty     (empty),
        .rd_en     (rd_en),
        .rdptr_bin (rdptr_bin),
        .rdptr_gray(rdptr_gray),
        .rvalid    (rvalid),
        .rdcount   (rdcount)
`ifdef CONTROLLER_RD_ALMOST_EMPTY_EN
        , .almost_empty(almost_empty)
`endif
    );

    always #5 rclk = ~rclk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] g2b(input logic [W-1:0] g);
        logic [W-1:0] b;
        b[W-1] = g[W-1];
        for (int i = W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    function automatic logic [W-1:0] b2g(input logic [W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Reference model: write-pointer pipeline, read pointer, expected-address scoreboard.
    logic [W-1:0] m_s1 = '0, m_s2 = '0, m_rd = '0;
    logic         m_rvalid = 1'b0;
    logic         m_empty, m_acc;
    logic [W-1:0] m_count;
    logic [W-1:0] exp_q[$];

    always_comb begin
        m_empty = !reset_L || (m_rd == g2b(m_s2));
        m_acc   = reset_L && pop && !m_empty;
        m_count = g2b(m_s2) - m_rd;
    end

    always @(posedge rclk) begin
        if (!reset_L) begin
            m_s1 <= '0;
            m_s2 <= '0;
            m_rd <= '0;
            m_rvalid <= 1'b0;
            exp_q.delete();
        end else begin
            m_s1 <= wrptr_gray;
            m_s2 <= m_s1;
            m_rvalid <= m_acc;
            if (m_acc) begin
                m_rd <= W'(m_rd + 1'b1);
                exp_q.push_back(W'(m_rd + 1'b1));
            end
        end
    end

    task automatic step();
        logic [W-1:0] prev_gray;
        logic [W-1:0] exp_ptr;
        prev_gray = rdptr_gray;
        @(posedge rclk);
        @(negedge rclk);
        check("rvalid", rvalid, m_rvalid);
        if (rvalid) begin
            if (exp_q.size() > 0) begin
                exp_ptr = exp_q.pop_front();
                check("sb_rdptr", rdptr_bin, exp_ptr);
            end else begin
                check("sb_nonempty", exp_q.size(), 1);
            end
        end
        check("empty", empty, m_empty);
        check("rdcount", rdcount, m_count);
        check("rd_en", rd_en, m_acc);
        check("gray_enc", rdptr_gray, b2g(rdptr_bin));
        if (reset_L) check("gray_step", 32'($countones(rdptr_gray ^ prev_gray) <= 1), 1);
`ifdef CONTROLLER_RD_ALMOST_EMPTY_EN
        check("almost_empty", almost_empty, !reset_L || (m_count <= 2));
`endif
    endtask

    task automatic do_reset();
        reset_L = 1'b0;
        pop = 1'b0;
        wrptr_gray = '0;
        step();
        step();
        reset_L = 1'b1;
    endtask

    initial begin
        logic [W-1:0] wr_bin;
        logic [W-1:0] prev_rd;
        int           accepted;
        int           wrapped;
        int           budget;

        // Reset state
        do_reset();
        check("rst_empty", empty, 1);
        check("rst_rdptr", rdptr_bin, 0);
        check("rst_gray", rdptr_gray, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_rdcount", rdcount, 0);

        // Write visibility: two-edge latency
        wrptr_gray = 5'b00010;
        step();
        check("vis_lag_empty", empty, 1);
        step();
        check("vis_empty", empty, 0);
        check("vis_count", rdcount, 3);

        // Four pops, three accepted
        pop = 1'b1;
        step();
        check("pop1_ptr", rdptr_bin, 1);
        check("pop1_rvalid", rvalid, 1);
        step();
        check("pop2_ptr", rdptr_bin, 2);
        step();
        check("pop3_ptr", rdptr_bin, 3);
        check("pop3_empty", empty, 1);
        check("pop3_rd_en", rd_en, 0);
        step();
        check("pop4_ptr", rdptr_bin, 3);
        check("pop4_rvalid", rvalid, 0);

        // Pop on empty
        step();
        check("pope_ptr", rdptr_bin, 3);
        check("pope_gray", rdptr_gray, 5'b00010);
        check("pope_rvalid", rvalid, 0);
        check("pope_rd_en", rd_en, 0);

        // Full aliasing: write pointer 16, read pointer 0
        do_reset();
        wrptr_gray = b2g(5'd16);
        step();
        step();
        check("full_empty", empty, 0);
        check("full_count", rdcount, 16);
`ifdef CONTROLLER_RD_ALMOST_EMPTY_EN
        check("full_almost", almost_empty, 0);
`endif

        // Wrap-around: 40 writes, 40 pops
        do_reset();
        wr_bin = '0;
        accepted = 0;
        wrapped = 0;
        pop = 1'b1;
        for (int i = 0; i < 40; i++) begin
            wr_bin = W'(wr_bin + 1'b1);
            wrptr_gray = b2g(wr_bin);
            prev_rd = rdptr_bin;
            step();
            if (rvalid) accepted++;
            if (prev_rd == 5'd31 && rdptr_bin == 5'd0) wrapped = 1;
        end
        budget = 0;
        while (!(empty && accepted == 40) && budget < 60) begin
            prev_rd = rdptr_bin;
            step();
            if (rvalid) accepted++;
            if (prev_rd == 5'd31 && rdptr_bin == 5'd0) wrapped = 1;
            budget++;
        end
        check("wrap_budget", 32'(budget < 60), 1);
        check("wrap_accepted", accepted, 40);
        check("wrap_seen", wrapped, 1);
        check("wrap_ptr", rdptr_bin, 8);
        check("wrap_empty", empty, 1);

        // Reset mid-burst
        do_reset();
        wrptr_gray = b2g(5'd10);
        step();
        step();
        pop = 1'b1;
        step();
        step();
        step();
        check("burst_ptr", rdptr_bin, 3);
        check("burst_rvalid", rvalid, 1);
        reset_L = 1'b0;
        #1;
        check("mid_rst_empty", empty, 1);
        check("mid_rst_rd_en", rd_en, 0);
`ifdef CONTROLLER_RD_ALMOST_EMPTY_EN
        check("mid_rst_almost", almost_empty, 1);
`endif
        step();
        check("mid_rst_rvalid", rvalid, 0);
        check("mid_rst_ptr", rdptr_bin, 0);
        check("mid_rst_count", rdcount, 0);
        reset_L = 1'b1;
        pop = 1'b0;
        wrptr_gray = b2g(5'd2);
        step();
        step();
        check("post_rst_count", rdcount, 2);
`ifdef CONTROLLER_RD_ALMOST_EMPTY_EN
        check("post_rst_almost", almost_empty, 1);
        wrptr_gray = b2g(5'd3);
        step();
        step();
        check("post_rst_almost3", almost_empty, 0);
`endif

        check("sb_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
